// File: rtl/branch_pc_unit.sv
// Purpose : PC register and branch resolution. Evaluates decoder strobes against
//           signed operands, redirects fetch, then holds flush for FLUSH_CYCLES cycles.
// Latency : redirect appears on pc one cycle after take is sampled; branch_taken/flush rise with it.
// Backpressure: stall freezes pc, state, counter and flush; strobes are not sampled while stalled.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   stall              hold all state (branch_taken still drops)
//   ctrl_valid         strobes/operands belong to a live instruction
//   branchEq..branchGte, jump, immType   decoder strobes / jump target select
//   branch_pc, offset, reg_target        target inputs
//   operand_a/b        signed compare operands
//   reset_vector       pc value loaded on reset
//   pc, flush, branch_taken              fetch address and redirect status
module branch_pc_unit #(
   parameter int unsigned PC_WIDTH     = 16,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned IMM_WIDTH    = 8,
   parameter int unsigned PC_STEP      = 1,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  ctrl_valid,
   input  logic                  branchEq,
   input  logic                  branchNeq,
   input  logic                  branchLt,
   input  logic                  branchGt,
   input  logic                  branchLte,
   input  logic                  branchGte,
   input  logic                  jump,
   input  logic                  immType,
   input  logic [PC_WIDTH-1:0]   branch_pc,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [IMM_WIDTH-1:0]  offset,
   input  logic [PC_WIDTH-1:0]   reg_target,
   input  logic [PC_WIDTH-1:0]   reset_vector,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  flush,
   output logic                  branch_taken
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXT_W = PC_WIDTH - IMM_WIDTH;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                flush_q, flush_d;
   logic                taken_q, taken_d;

   // ---------------- condition evaluation ----------------
   logic                a_eq, a_lt, a_gt;
   logic                cond_hit;
   logic                take;
   logic [PC_WIDTH-1:0] offset_sext;
   logic [PC_WIDTH-1:0] rel_target;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] pc_inc;

   assign a_eq = (operand_a == operand_b);
   assign a_lt = ($signed(operand_a) < $signed(operand_b));
   assign a_gt = ($signed(operand_a) > $signed(operand_b));

   // Several strobes may be high at once; any satisfied condition takes the branch.
   assign cond_hit = (branchEq  &  a_eq)
                   | (branchNeq & ~a_eq)
                   | (branchLt  &  a_lt)
                   | (branchGt  &  a_gt)
                   | (branchLte & (a_lt | a_eq))
                   | (branchGte & (a_gt | a_eq));

   assign take = ctrl_valid & (jump | cond_hit);

   // Address arithmetic wraps silently modulo 2^PC_WIDTH.
   assign offset_sext = {{EXT_W{offset[IMM_WIDTH-1]}}, offset};
   assign rel_target  = branch_pc + offset_sext;
   // Only a register-target jump departs from the PC-relative target, so a
   // jump with immType=1 and any conditional branch share rel_target.
   assign target      = (jump & ~immType) ? reg_target : rel_target;
   assign pc_inc      = pc_q + PC_WIDTH'(PC_STEP);

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      taken_d = 1'b0;

      if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (take) begin
                  pc_d    = target;
                  taken_d = 1'b1;
                  cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                  flush_d = 1'b1;
                  state_d = ST_FLUSH;
               end else begin
                  pc_d = pc_inc;
               end
            end
            ST_FLUSH: begin
               // Strobes here come from squashed instructions and are ignored.
               pc_d = pc_inc;
               if (cnt_q == '0) begin
                  flush_d = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_RUN;
               flush_d = 1'b0;
            end
         endcase
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= reset_vector;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         taken_q <= taken_d;
      end
   end

   assign pc           = pc_q;
   assign flush        = flush_q;
   assign branch_taken = taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Purpose : directed-vector scoreboard bench for branch_pc_unit.
// Latency : one expected entry per clock, compared one step after the rising edge.
// Backpressure: stall is driven directly by the stimulus vectors.
module tb_branch_pc_unit;

   logic        clock = 1'b0;
   logic        reset, stall, ctrl_valid;
   logic        branchEq, branchNeq, branchLt, branchGt, branchLte, branchGte;
   logic        jump, immType;
   logic [15:0] branch_pc, operand_a, operand_b, reg_target, reset_vector;
   logic [7:0]  offset;
   logic [15:0] pc;
   logic        flush, branch_taken;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] pc;
      logic        fl;
      logic        tk;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   always #5 clock = ~clock;

   branch_pc_unit dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .ctrl_valid   (ctrl_valid),
      .branchEq     (branchEq),
      .branchNeq    (branchNeq),
      .branchLt     (branchLt),
      .branchGt     (branchGt),
      .branchLte    (branchLte),
      .branchGte    (branchGte),
      .jump         (jump),
      .immType      (immType),
      .branch_pc    (branch_pc),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .offset       (offset),
      .reg_target   (reg_target),
      .reset_vector (reset_vector),
      .pc           (pc),
      .flush        (flush),
      .branch_taken (branch_taken)
   );

   // Monitor: the DUT presents a new state every clock; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc) begin
               errors++;
               $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
            end
            checks++;
            if (flush !== e.fl) begin
               errors++;
               $display("FAIL %s flush: got %b expected %b", e.name, flush, e.fl);
            end
            checks++;
            if (branch_taken !== e.tk) begin
               errors++;
               $display("FAIL %s branch_taken: got %b expected %b", e.name, branch_taken, e.tk);
            end
         end
      end
   end

   task automatic clr();
      ctrl_valid = 1'b0;
      branchEq = 1'b0; branchNeq = 1'b0; branchLt = 1'b0;
      branchGt = 1'b0; branchLte = 1'b0; branchGte = 1'b0;
      jump = 1'b0; immType = 1'b0;
   endtask

   // Inputs are already set by the caller (at a falling edge); queue the state
   // expected after the next rising edge, then move to the next falling edge.
   task automatic step(input logic [15:0] epc, input logic efl, input logic etk, input string nm);
      exp_t e;
      e.pc = epc; e.fl = efl; e.tk = etk; e.name = nm;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   initial begin
      clr();
      stall = 1'b0;
      reset = 1'b1;
      reset_vector = 16'h0010;
      branch_pc = 16'h0000; operand_a = 16'h0000; operand_b = 16'h0000;
      offset = 8'h00; reg_target = 16'h0000;

      // Sequential fetch from reset vector
      step(16'h0010, 1'b0, 1'b0, "reset");
      reset = 1'b0;
      step(16'h0011, 1'b0, 1'b0, "seq1");
      step(16'h0012, 1'b0, 1'b0, "seq2");
      step(16'h0013, 1'b0, 1'b0, "seq3");
      step(16'h0014, 1'b0, 1'b0, "seq4");

      // Signed branchLt taken: -2 < 3, 0x0040 + (-8) = 0x0038
      ctrl_valid = 1'b1; branchLt = 1'b1;
      operand_a = 16'hFFFE; operand_b = 16'h0003;
      branch_pc = 16'h0040; offset = 8'hF8;
      step(16'h0038, 1'b1, 1'b1, "blt_take");
      clr();
      step(16'h0039, 1'b1, 1'b0, "blt_flush2");
      step(16'h003A, 1'b0, 1'b0, "blt_done");

      // Not-taken branchEq (5 != 6)
      ctrl_valid = 1'b1; branchEq = 1'b1;
      operand_a = 16'd5; operand_b = 16'd6;
      step(16'h003B, 1'b0, 1'b0, "beq_nt");
      // jump without ctrl_valid must not redirect
      clr(); jump = 1'b1; reg_target = 16'h7777;
      step(16'h003C, 1'b0, 1'b0, "jump_novalid");

      // Register jump wins over a taken branchNeq
      clr(); ctrl_valid = 1'b1; jump = 1'b1; immType = 1'b0; reg_target = 16'h1234;
      branchNeq = 1'b1; operand_a = 16'd1; operand_b = 16'd2;
      branch_pc = 16'h0040; offset = 8'h10;
      step(16'h1234, 1'b1, 1'b1, "jreg_wins");
      // Jump presented during FLUSH is ignored
      clr(); ctrl_valid = 1'b1; jump = 1'b1; immType = 1'b1;
      branch_pc = 16'h0500; offset = 8'h04;
      step(16'h1235, 1'b1, 1'b0, "flush_ign1");
      step(16'h1236, 1'b0, 1'b0, "flush_ign2");
      clr();

      // Stall during flush: 0x0100 + 0x20 = 0x0120
      ctrl_valid = 1'b1; jump = 1'b1; immType = 1'b1;
      branch_pc = 16'h0100; offset = 8'h20;
      step(16'h0120, 1'b1, 1'b1, "jimm_take");
      clr(); stall = 1'b1;
      step(16'h0120, 1'b1, 1'b0, "stall1");
      step(16'h0120, 1'b1, 1'b0, "stall2");
      step(16'h0120, 1'b1, 1'b0, "stall3");
      stall = 1'b0;
      step(16'h0121, 1'b1, 1'b0, "post_stall1");
      step(16'h0122, 1'b0, 1'b0, "post_stall2");

      // Reset during flush, while also stalled
      ctrl_valid = 1'b1; jump = 1'b1; immType = 1'b0; reg_target = 16'h0200;
      step(16'h0200, 1'b1, 1'b1, "jreg_take");
      clr(); reset = 1'b1; stall = 1'b1;
      step(16'h0010, 1'b0, 1'b0, "reset_in_flush");
      reset = 1'b0; stall = 1'b0;
      // State RUN after reset: a taken branchGte is accepted immediately (3>=3)
      ctrl_valid = 1'b1; branchGte = 1'b1;
      operand_a = 16'd3; operand_b = 16'd3;
      branch_pc = 16'h0011; offset = 8'h7F;
      step(16'h0090, 1'b1, 1'b1, "bge_after_rst");
      clr();
      step(16'h0091, 1'b1, 1'b0, "bge_flush2");
      step(16'h0092, 1'b0, 1'b0, "bge_done");

      // Signed branchLte: -32768 <= 32767
      ctrl_valid = 1'b1; branchLte = 1'b1;
      operand_a = 16'h8000; operand_b = 16'h7FFF;
      branch_pc = 16'h0010; offset = 8'h01;
      step(16'h0011, 1'b1, 1'b1, "ble_signed");
      clr();
      step(16'h0012, 1'b1, 1'b0, "ble_flush2");
      step(16'h0013, 1'b0, 1'b0, "ble_done");

      // Sequential wrap-around 0xFFFF -> 0x0000
      ctrl_valid = 1'b1; jump = 1'b1; immType = 1'b0; reg_target = 16'hFFFD;
      step(16'hFFFD, 1'b1, 1'b1, "j_fffd");
      clr();
      step(16'hFFFE, 1'b1, 1'b0, "wrap_f2");
      step(16'hFFFF, 1'b0, 1'b0, "wrap_ffff");
      step(16'h0000, 1'b0, 1'b0, "wrap_seq");

      // Target wrap-around: 0xFFFE + 5 = 0x0003; signed 1 > -1 taken
      ctrl_valid = 1'b1; branchGt = 1'b1;
      operand_a = 16'h0001; operand_b = 16'hFFFF;
      branch_pc = 16'hFFFE; offset = 8'h05;
      step(16'h0003, 1'b1, 1'b1, "wrap_target");
      clr();
      step(16'h0004, 1'b1, 1'b0, "wrap_t_f2");
      step(16'h0005, 1'b0, 1'b0, "wrap_t_done");

      // Drain: bounded wait for the monitor to consume everything
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
